// File: rtl/fetch_unit_if.sv
// Bundle of the fetch unit's memory-side and consumer-side handshakes.
// The master modport is the fetch unit; the slave modport is memory plus the decode stage.
interface fetch_unit_if;
    logic [15:0] mem_address;
    logic        mem_read;
    logic [15:0] mem_rdata;
    logic        mem_resp;
    logic [15:0] inst_word;
    logic [15:0] inst_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic        redirect;
    logic [15:0] redirect_pc;

    modport master (
        output mem_address, mem_read, inst_word, inst_pc, inst_valid,
        input  mem_rdata, mem_resp, inst_ready, redirect, redirect_pc
    );

    modport slave (
        input  mem_address, mem_read, inst_word, inst_pc, inst_valid,
        output mem_rdata, mem_resp, inst_ready, redirect, redirect_pc
    );
endinterface

// File: rtl/fetch_unit.sv
// LC-3b instruction fetch unit feeding a small prefetch buffer.
// Define FETCH_PREFETCH_BUF_EN for a 2-entry buffer; otherwise a single holding register.
module fetch_unit (
    input  logic         clk,
    input  logic         reset,
    fetch_unit_if.master bus
);

`ifdef FETCH_PREFETCH_BUF_EN
    localparam logic [1:0] DEPTH = 2'd2;
`else
    localparam logic [1:0] DEPTH = 2'd1;
`endif

    typedef enum logic [1:0] {IDLE, FETCH, HOLD, DROP} state_t;

    state_t      state;
    logic [15:0] fetch_pc;
    logic [15:0] drop_pc;
    logic [15:0] buf_word [2];
    logic [15:0] buf_pc   [2];
    logic        head;
    logic        tail;
    logic [1:0]  count;

    logic        push;
    logic        pop;
    logic [1:0]  count_after;
    logic [15:0] pc_plus2;
    logic [15:0] redirect_target;

    // Pointers only move in the two-entry build; the single-register build pins them at 0.
    function automatic logic next_ptr(input logic p);
        return (DEPTH == 2'd2) ? ~p : 1'b0;
    endfunction

    always_comb begin
        push        = (state == FETCH) && bus.mem_resp && !bus.redirect;
        pop         = (count != 2'd0) && bus.inst_ready && !bus.redirect;
        count_after = count + {1'b0, push} - {1'b0, pop};
    end

    assign pc_plus2        = fetch_pc + 16'd2;
    assign redirect_target = bus.redirect_pc & 16'hFFFE;

    // A redirect empties the buffer outright; a read already on the bus cannot be
    // cancelled, so DROP waits for its response and throws the data away.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            fetch_pc <= 16'h0000;
            drop_pc  <= 16'h0000;
            head     <= 1'b0;
            tail     <= 1'b0;
            count    <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                buf_word[i] <= 16'h0000;
                buf_pc[i]   <= 16'h0000;
            end
        end else begin
            if (push) begin
                buf_word[tail] <= bus.mem_rdata;
                buf_pc[tail]   <= pc_plus2;
                tail           <= next_ptr(tail);
            end
            if (pop) begin
                head <= next_ptr(head);
            end
            count <= count_after;
            if (bus.redirect) begin
                head  <= 1'b0;
                tail  <= 1'b0;
                count <= 2'd0;
            end

            case (state)
                IDLE: begin
                    state <= FETCH;
                    if (bus.redirect) begin
                        fetch_pc <= redirect_target;
                    end
                end
                FETCH: begin
                    if (bus.redirect) begin
                        if (bus.mem_resp) begin
                            fetch_pc <= redirect_target;
                        end else begin
                            drop_pc <= redirect_target;
                            state   <= DROP;
                        end
                    end else if (bus.mem_resp) begin
                        fetch_pc <= pc_plus2;
                        state    <= (count_after < DEPTH) ? FETCH : HOLD;
                    end
                end
                HOLD: begin
                    if (bus.redirect) begin
                        fetch_pc <= redirect_target;
                        state    <= FETCH;
                    end else if (count_after < DEPTH) begin
                        state <= FETCH;
                    end
                end
                DROP: begin
                    if (bus.mem_resp) begin
                        fetch_pc <= bus.redirect ? redirect_target : drop_pc;
                        state    <= FETCH;
                    end else if (bus.redirect) begin
                        drop_pc <= redirect_target;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.mem_address = fetch_pc;
    assign bus.mem_read    = (state == FETCH) || (state == DROP);
    assign bus.inst_valid  = (count != 2'd0);
    assign bus.inst_word   = buf_word[head];
    assign bus.inst_pc     = buf_pc[head];

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: vector table, directed corner cases and a
// randomized run checked against an instruction-stream model.
module tb_fetch_unit;

`ifdef FETCH_PREFETCH_BUF_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif
    localparam logic AHEAD = (DEPTH == 2);

    typedef struct {
        logic        rst;
        logic        resp;
        logic [15:0] rdata;
        logic        ready;
        logic        redir;
        logic [15:0] rpc;
        logic        exp_read;
        logic [15:0] exp_addr;
        logic        exp_valid;
        logic        chk_data;
        logic [15:0] exp_word;
        logic [15:0] exp_pc;
    } vec_t;

    logic clk;
    logic reset;
    fetch_unit_if bus();

    fetch_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int          compared;
    int          mismatched;
    int          drained;
    int          handshakes;
    logic        ok;
    vec_t        vecs [9];
    logic [15:0] exp_pc;
    logic        prev_read;
    logic        prev_resp;
    logic [15:0] prev_addr;
    logic        prev_hold;
    logic [15:0] prev_word;
    logic [15:0] prev_ipc;
    logic        prev_redir;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Memory contents: every address holds a word derived from its own address.
    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h9E37;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [15:0] actual,
                               input logic [15:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic clear_inputs();
        bus.mem_resp    = 1'b0;
        bus.mem_rdata   = 16'h0000;
        bus.inst_ready  = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 16'h0000;
    endtask

    task automatic applyStimulus(input vec_t v);
        reset           = v.rst;
        bus.mem_resp    = v.resp;
        bus.mem_rdata   = v.rdata;
        bus.inst_ready  = v.ready;
        bus.redirect    = v.redir;
        bus.redirect_pc = v.rpc;
        tick();
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        reset      = 1'b1;
        clear_inputs();

        //          rst   resp  rdata     rdy   redir rpc       read   addr      vld   chk   word      pc
        vecs[0] = '{1'b1, 1'b1, 16'h7777, 1'b0, 1'b0, 16'h0000, 1'b0,  16'h0000, 1'b0, 1'b1, 16'h0000, 16'h0000};
        vecs[1] = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0,  16'h0000, 1'b0, 1'b1, 16'h0000, 16'h0000};
        vecs[2] = '{1'b0, 1'b1, 16'hFFFF, 1'b1, 1'b0, 16'h0000, 1'b1,  16'h0000, 1'b0, 1'b1, 16'h0000, 16'h0000};
        vecs[3] = '{1'b0, 1'b1, 16'h1261, 1'b1, 1'b0, 16'h0000, AHEAD, 16'h0002, 1'b1, 1'b1, 16'h1261, 16'h0002};
        vecs[4] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1,  16'h0002, 1'b0, 1'b0, 16'h0000, 16'h0000};
        vecs[5] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'hFFFF, 1'b1,  16'h0002, 1'b0, 1'b0, 16'h0000, 16'h0000};
        vecs[6] = '{1'b0, 1'b1, 16'hDEAD, 1'b0, 1'b0, 16'h0000, 1'b1,  16'hFFFE, 1'b0, 1'b0, 16'h0000, 16'h0000};
        vecs[7] = '{1'b0, 1'b1, 16'hABCD, 1'b0, 1'b0, 16'h0000, AHEAD, 16'h0000, 1'b1, 1'b1, 16'hABCD, 16'h0000};
        vecs[8] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, AHEAD, 16'h0000, 1'b1, 1'b1, 16'hABCD, 16'h0000};

        for (int i = 0; i < 9; i++) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("vec%0d_mem_read", i), {15'd0, bus.mem_read}, {15'd0, vecs[i].exp_read});
            checkOutput($sformatf("vec%0d_mem_address", i), bus.mem_address, vecs[i].exp_addr);
            checkOutput($sformatf("vec%0d_inst_valid", i), {15'd0, bus.inst_valid}, {15'd0, vecs[i].exp_valid});
            if (vecs[i].chk_data) begin
                checkOutput($sformatf("vec%0d_inst_word", i), bus.inst_word, vecs[i].exp_word);
                checkOutput($sformatf("vec%0d_inst_pc", i), bus.inst_pc, vecs[i].exp_pc);
            end
        end
        clear_inputs();

        // Backpressure: memory answers every request, consumer stalls.
        do_reset();
        tick();
        for (int i = 0; i < 20; i++) begin
            bus.mem_resp  = bus.mem_read;
            bus.mem_rdata = mem_word(bus.mem_address);
            tick();
        end
        bus.mem_resp = 1'b0;
        checkOutput("bp_mem_read", {15'd0, bus.mem_read}, 16'd0);
        checkOutput("bp_valid", {15'd0, bus.inst_valid}, 16'd1);
        checkOutput("bp_word", bus.inst_word, mem_word(16'h0000));
        checkOutput("bp_pc", bus.inst_pc, 16'h0002);
        drained = 0;
        bus.inst_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (bus.inst_valid) drained++;
            tick();
        end
        bus.inst_ready = 1'b0;
        checkOutput("bp_depth", 16'(drained), 16'(DEPTH));

        // Redirect while the read to 0x0004 is still outstanding.
        do_reset();
        tick();
        bus.inst_ready = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            if (bus.mem_read && bus.mem_address == 16'h0004 && !bus.inst_valid) begin
                ok = 1'b1;
            end else begin
                bus.mem_resp  = bus.mem_read && (bus.mem_address < 16'h0004);
                bus.mem_rdata = mem_word(bus.mem_address);
                tick();
            end
        end
        clear_inputs();
        checkOutput("mid_reach", {15'd0, ok}, 16'd1);
        bus.redirect    = 1'b1;
        bus.redirect_pc = 16'h3001;
        tick();
        clear_inputs();
        for (int k = 0; k < 3; k++) begin
            checkOutput($sformatf("mid_wait%0d_addr", k), bus.mem_address, 16'h0004);
            checkOutput($sformatf("mid_wait%0d_read", k), {15'd0, bus.mem_read}, 16'd1);
            checkOutput($sformatf("mid_wait%0d_valid", k), {15'd0, bus.inst_valid}, 16'd0);
            if (k < 2) tick();
        end
        bus.mem_resp  = 1'b1;
        bus.mem_rdata = 16'hBEEF;
        tick();
        bus.mem_resp = 1'b0;
        checkOutput("mid_target_addr", bus.mem_address, 16'h3000);
        checkOutput("mid_target_read", {15'd0, bus.mem_read}, 16'd1);
        checkOutput("mid_dropped_valid", {15'd0, bus.inst_valid}, 16'd0);
        bus.mem_resp  = 1'b1;
        bus.mem_rdata = 16'h5555;
        tick();
        bus.mem_resp = 1'b0;
        checkOutput("mid_first_valid", {15'd0, bus.inst_valid}, 16'd1);
        checkOutput("mid_first_word", bus.inst_word, 16'h5555);
        checkOutput("mid_first_pc", bus.inst_pc, 16'h3002);

        // Redirect, response and consume all in the same cycle on a full buffer.
        do_reset();
        tick();
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (!bus.mem_read) begin
                ok = 1'b1;
            end else begin
                bus.mem_resp  = 1'b1;
                bus.mem_rdata = mem_word(bus.mem_address);
                tick();
            end
        end
        bus.mem_resp = 1'b0;
        checkOutput("full_reach", {15'd0, ok}, 16'd1);
        bus.redirect    = 1'b1;
        bus.redirect_pc = 16'h4445;
        bus.mem_resp    = 1'b1;
        bus.mem_rdata   = 16'h1111;
        bus.inst_ready  = 1'b1;
        tick();
        clear_inputs();
        checkOutput("full_flush_valid", {15'd0, bus.inst_valid}, 16'd0);
        checkOutput("full_target_addr", bus.mem_address, 16'h4444);
        checkOutput("full_target_read", {15'd0, bus.mem_read}, 16'd1);
        tick();
        checkOutput("full_still_empty", {15'd0, bus.inst_valid}, 16'd0);
        bus.mem_resp  = 1'b1;
        bus.mem_rdata = mem_word(bus.mem_address);
        tick();
        bus.mem_resp = 1'b0;
        checkOutput("full_first_pc", bus.inst_pc, 16'h4446);

        // Randomized run: the consumed stream must be consecutive words from the last target.
        do_reset();
        tick();
        exp_pc     = 16'h0000;
        handshakes = 0;
        prev_read  = 1'b0;
        prev_resp  = 1'b0;
        prev_addr  = 16'h0000;
        prev_hold  = 1'b0;
        prev_word  = 16'h0000;
        prev_ipc   = 16'h0000;
        prev_redir = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (prev_read && !prev_resp) begin
                checkOutput("rnd_read_held", {15'd0, bus.mem_read}, 16'd1);
                checkOutput("rnd_addr_stable", bus.mem_address, prev_addr);
            end
            if (prev_hold) begin
                checkOutput("rnd_hold_valid", {15'd0, bus.inst_valid}, 16'd1);
                checkOutput("rnd_hold_word", bus.inst_word, prev_word);
                checkOutput("rnd_hold_pc", bus.inst_pc, prev_ipc);
            end
            if (prev_redir) begin
                checkOutput("rnd_flush", {15'd0, bus.inst_valid}, 16'd0);
            end
            bus.inst_ready  = ($urandom_range(0, 9) < 6);
            bus.mem_resp    = bus.mem_read && ($urandom_range(0, 1) == 1);
            bus.mem_rdata   = bus.mem_resp ? mem_word(bus.mem_address) : 16'($urandom);
            bus.redirect    = ($urandom_range(0, 29) == 0);
            bus.redirect_pc = 16'($urandom);
            if (bus.redirect) begin
                exp_pc = bus.redirect_pc & 16'hFFFE;
            end else if (bus.inst_valid && bus.inst_ready) begin
                checkOutput("rnd_word", bus.inst_word, mem_word(exp_pc));
                checkOutput("rnd_pc", bus.inst_pc, exp_pc + 16'd2);
                exp_pc = exp_pc + 16'd2;
                handshakes++;
            end
            prev_read  = bus.mem_read;
            prev_resp  = bus.mem_resp;
            prev_addr  = bus.mem_address;
            prev_hold  = bus.inst_valid && !bus.inst_ready && !bus.redirect;
            prev_word  = bus.inst_word;
            prev_ipc   = bus.inst_pc;
            prev_redir = bus.redirect;
            tick();
        end
        clear_inputs();
        checkOutput("rnd_progress", {15'd0, handshakes >= 200}, 16'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have port: mem_address  output  16  instruction memory word address (= fetch PC).
REQ-004 SHALL have port: mem_read  output  1  read request; held high with stable mem_address until mem_resp.
REQ-005 SHALL have port: mem_rdata  input  16  instruction data, valid when mem_resp=1.
REQ-006 SHALL have port: mem_resp  input  1  one-cycle completion of the outstanding read.
REQ-007 SHALL have port: inst_word  output  16  instruction at buffer head, for IR `in`.
REQ-008 SHALL have port: inst_pc  output  16  PC of inst_word plus 2 (LC-3b incremented PC).
REQ-009 SHALL have port: inst_valid  output  1  buffer head holds a valid instruction.
REQ-010 SHALL have port: inst_ready  input  1  consumer takes head this cycle (drives IR load).
REQ-011 SHALL have port: redirect  input  1  control-flow change (branch/JMP/JSR/TRAP taken).
REQ-012 SHALL have port: redirect_pc  input  16  new fetch target; bit 0 ignored.

Function
REQ-013 SHALL implement states IDLE, FETCH, HOLD, DROP; mem_read=1 exactly in FETCH and DROP.
REQ-014 SHALL go IDLE->FETCH unconditionally one cycle after reset deasserts.
REQ-015 SHALL in FETCH on mem_resp write {mem_rdata, fetch_pc+2} into buffer tail and advance fetch_pc by 2.
REQ-016 SHALL compute fetch_pc+2 modulo 2^16 (16'hFFFE wraps to 16'h0000).
REQ-017 SHALL issue a new read only if (occupancy + outstanding) < DEPTH; otherwise go/stay HOLD.
REQ-018 SHALL leave HOLD for FETCH in the cycle after a consume frees a slot.
REQ-019 SHALL count a handshake as inst_valid & inst_ready; head popped at that edge.
REQ-020 SHALL keep occupancy unchanged on simultaneous push (mem_resp) and pop.
REQ-021 SHALL present inst_valid=1 the cycle after the mem_resp that fills an empty buffer (1-cycle latency).
REQ-022 SHALL hold inst_word/inst_pc stable while inst_valid=1 and inst_ready=0.
REQ-023 SHALL on redirect flush all buffer entries, set fetch_pc={redirect_pc[15:1],1'b0}; inst_valid=0 next cycle.
REQ-024 SHALL give redirect priority over a same-cycle pop or mem_resp push (pushed word discarded).
REQ-025 SHALL on redirect with read outstanding and no same-cycle mem_resp enter DROP, keeping old mem_address until mem_resp, discard that data, then enter FETCH at the redirect target.
REQ-026 SHALL on redirect while in DROP update the target to the latest redirect_pc.
REQ-027 SHALL ignore inst_ready when inst_valid=0 (no underflow).

Reset
REQ-028 SHALL on reset set state=IDLE, fetch_pc=16'h0000, occupancy=0, mem_read=0, inst_valid=0, inst_word=16'h0000, inst_pc=16'h0000.
REQ-029 SHALL abandon any outstanding read on reset; a mem_resp arriving in IDLE SHALL be ignored.

Configuration
REQ-030 SHALL honour macro FETCH_PREFETCH_BUF_EN.
REQ-031 SHALL with FETCH_PREFETCH_BUF_EN defined use DEPTH=2 (circular buffer, head/tail wrap 1->0), allowing one fetch ahead of the consumer.
REQ-032 SHALL without FETCH_PREFETCH_BUF_EN use DEPTH=1 (single register); next read issues only after the held word is consumed.

Verification
REQ-033 SHALL verify reset: reset 2 cycles, release -> mem_read=0 one cycle, then mem_read=1, mem_address=16'h0000.
REQ-034 SHALL verify fetch: mem_resp with mem_rdata=16'h1261 at 0x0000, inst_ready=1 -> next cycle inst_word=16'h1261, inst_pc=16'h0002, mem_address=16'h0002.
REQ-035 SHALL verify backpressure: inst_ready=0, memory always responding -> with macro 2 words buffered, mem_read=0 (HOLD); without macro 1 word buffered.
REQ-036 SHALL verify redirect mid-read: redirect_pc=16'h3001 while read to 0x0004 pending, resp 3 cycles later -> data discarded, next mem_address=16'h3000, inst_valid=0 meanwhile.
REQ-037 SHALL verify wrap: fetch at 16'hFFFE -> inst_pc=16'h0000, next mem_address=16'h0000.
REQ-038 SHALL verify simultaneous redirect+mem_resp+inst_ready on full buffer -> buffer empty, next mem_address=redirect target.
